// File: rtl/mb_cfg_pkg.sv
// mb_cfg_pkg: types shared by the config bus master and the
// median_filter register map (op codes, FSM states, bus widths).
package mb_cfg_pkg;

    localparam int DW_MA_DEF = 8;
    localparam int DW_MD_DEF = 16;

    typedef enum logic [1:0] {
        OP_WR  = 2'b00,
        OP_RD  = 2'b01,
        OP_WRV = 2'b10,
        OP_ILL = 2'b11
    } mb_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_GAP,
        ST_RD,
        ST_RESP
    } mb_state_e;

endpackage

// File: rtl/mb_config_master.sv
// mb_config_master: memory (config) bus initiator. Takes register
// commands on a valid/ready queue and returns one response each.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   cmd_val/cmd_rdy     command handshake
//   cmd_op/adr/wdt/msk  op (WR, RD, WRV, illegal), address, data, mask
//   rsp_val/dat/err     one-cycle response pulse, data, error flag
//   err_sticky/err_clr  accumulated error flag and its clear
//   m_mb_adr/wdt/val    bus address, write data, write strobe
//   m_mb_rdt            bus read data
module mb_config_master
    import mb_cfg_pkg::*;
#(
    parameter int DW_MA  = DW_MA_DEF,
    parameter int DW_MD  = DW_MD_DEF,
    parameter int WR_GAP = 1,
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_val,
    output logic             cmd_rdy,
    input  logic [1:0]       cmd_op,
    input  logic [DW_MA-1:0] cmd_adr,
    input  logic [DW_MD-1:0] cmd_wdt,
    input  logic [DW_MD-1:0] cmd_msk,
    output logic             rsp_val,
    output logic [DW_MD-1:0] rsp_dat,
    output logic             rsp_err,
    output logic             err_sticky,
    input  logic             err_clr,
    output logic [DW_MA-1:0] m_mb_adr,
    output logic [DW_MD-1:0] m_mb_wdt,
    input  logic [DW_MD-1:0] m_mb_rdt,
    output logic             m_mb_val
);

    localparam int CNT_MAX = (WR_GAP > RD_LAT) ? WR_GAP : RD_LAT;
    localparam int CW = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
    localparam logic [CW-1:0] GAP_LD = CW'((WR_GAP > 0) ? WR_GAP - 1 : 0);
    localparam logic [CW-1:0] RD_LD = CW'(RD_LAT);

    mb_state_e        state_q, state_d;
    mb_state_e        after_wr;
    mb_op_e           op_q, op_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [DW_MA-1:0] adr_q, adr_d;
    logic [DW_MD-1:0] wdt_q, wdt_d;
    logic [DW_MD-1:0] msk_q, msk_d;
    logic [DW_MD-1:0] dat_q, dat_d;
    logic             err_q, err_d;
    logic             sticky_q, sticky_d;

    // Write-verify reads back the same address once the write settles.
    assign after_wr = (op_q == OP_WRV) ? ST_RD : ST_RESP;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        adr_d    = adr_q;
        wdt_d    = wdt_q;
        msk_d    = msk_q;
        dat_d    = dat_q;
        err_d    = err_q;
        sticky_d = sticky_q;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_val) begin
                    op_d  = mb_op_e'(cmd_op);
                    msk_d = cmd_msk;
                    dat_d = '0;
                    err_d = 1'b0;
                    unique case (mb_op_e'(cmd_op))
                        OP_ILL: begin
                            // No bus activity: bus regs keep old values.
                            err_d   = 1'b1;
                            state_d = ST_RESP;
                        end
                        OP_RD: begin
                            adr_d   = cmd_adr;
                            cnt_d   = RD_LD;
                            state_d = ST_RD;
                        end
                        default: begin
                            adr_d   = cmd_adr;
                            wdt_d   = cmd_wdt;
                            state_d = ST_WR;
                        end
                    endcase
                end
            end
            ST_WR: begin
                if (WR_GAP > 0) begin
                    cnt_d   = GAP_LD;
                    state_d = ST_GAP;
                end else begin
                    cnt_d   = RD_LD;
                    state_d = after_wr;
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    cnt_d   = RD_LD;
                    state_d = after_wr;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RD: begin
                if (cnt_q == '0) begin
                    dat_d   = m_mb_rdt;
                    err_d   = (op_q == OP_WRV) &&
                              (|((m_mb_rdt ^ wdt_q) & msk_q));
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // A new error beats a simultaneous clear.
        if (state_q == ST_RESP && err_q) begin
            sticky_d = 1'b1;
        end else if (err_clr) begin
            sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_WR;
            cnt_q    <= '0;
            adr_q    <= '0;
            wdt_q    <= '0;
            msk_q    <= '0;
            dat_q    <= '0;
            err_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            adr_q    <= adr_d;
            wdt_q    <= wdt_d;
            msk_q    <= msk_d;
            dat_q    <= dat_d;
            err_q    <= err_d;
            sticky_q <= sticky_d;
        end
    end

    assign cmd_rdy    = (state_q == ST_IDLE);
    assign m_mb_val   = (state_q == ST_WR);
    assign m_mb_adr   = adr_q;
    assign m_mb_wdt   = wdt_q;
    assign rsp_val    = (state_q == ST_RESP);
    assign rsp_dat    = rsp_val ? dat_q : '0;
    assign rsp_err    = rsp_val & err_q;
    assign err_sticky = sticky_q;

endmodule
